// File: rtl/char_slot_scheduler.sv
`timescale 1ns/1ps
// Purpose : pool of falling-character slots for the typing game. It spawns characters,
//           advances them once per frame, matches key presses, and keeps score/misses/gameover.
// Latency : a spawn takes 1 cycle. A frame step takes NSLOTS cycles. A key match takes NSLOTS+1
//           cycles. Event pulses are registered. The read port has 1 cycle of latency.
// Backpressure: spawn_ready drops while busy, while a request is pending, when the pool is full
//           or after gameover. Ticks and keys that arrive while busy are held one deep.
// Ports   : clk/rst_n; enable and clear from the game FSM;
//           spawn_* valid/ready from the generator; frame_tick;
//           key_valid/key_ascii; rd_idx -> rd_* registered read port for the renderer;
//           hit/miss/wrong pulses; score, miss_cnt, gameover, busy and overrun status.
module char_slot_scheduler #(
  parameter int NSLOTS      = 16,
  parameter int LOWER_BOUND = 480,
  parameter int MAX_MISS    = 3,
  parameter int SCORE_MAX   = 99
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      spawn_valid,
  input  logic [7:0]                spawn_ascii,
  input  logic [9:0]                spawn_x,
  input  logic [2:0]                spawn_speed,
  output logic                      spawn_ready,
  input  logic                      frame_tick,
  input  logic                      key_valid,
  input  logic [7:0]                key_ascii,
  input  logic [$clog2(NSLOTS)-1:0] rd_idx,
  output logic                      rd_valid,
  output logic [7:0]                rd_ascii,
  output logic [9:0]                rd_x,
  output logic [9:0]                rd_y,
  output logic                      hit,
  output logic                      miss,
  output logic                      wrong,
  output logic [7:0]                score,
  output logic [1:0]                miss_cnt,
  output logic                      gameover,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IW = $clog2(NSLOTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLOTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_MATCH, S_RETIRE} state_t;

  // Slot storage
  logic       slot_vld_q   [NSLOTS];
  logic [7:0] slot_ascii_q [NSLOTS];
  logic [9:0] slot_x_q     [NSLOTS];
  logic [9:0] slot_y_q     [NSLOTS];
  logic [2:0] slot_spd_q   [NSLOTS];

  // Control state
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pend_tick_q, pend_tick_d;
  logic          pend_key_q, pend_key_d;
  logic [7:0]    pend_code_q, pend_code_d;
  logic [7:0]    match_key_q, match_key_d;
  logic          found_q, found_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [9:0]    best_y_q, best_y_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    miss_cnt_q, miss_cnt_d;
  logic          gameover_q, gameover_d;
  logic          overrun_q, overrun_d;
  logic          hit_q, hit_d, miss_q, miss_d, wrong_q, wrong_d;

  logic          rd_vld_q;
  logic [7:0]    rd_ascii_q;
  logic [9:0]    rd_x_q, rd_y_q;

  // Request qualification
  logic          in_idle, tick_arr, key_arr, tick_serve, key_serve, spawn_go;
  logic          free_vld;
  logic [IW-1:0] free_idx;
  logic          cur_vld;
  logic [7:0]    cur_ascii;
  logic [9:0]    cur_y, y_new;
  logic          step_wr, step_miss, retire_hit;
  logic [1:0]    miss_inc;

  assign in_idle    = (state_q == S_IDLE);
  assign tick_arr   = frame_tick & enable & ~clear & ~gameover_q;
  assign key_arr    = key_valid & enable & ~clear & ~gameover_q;
  assign tick_serve = in_idle & (pend_tick_q | tick_arr) & enable & ~clear & ~gameover_q;
  assign key_serve  = in_idle & (pend_key_q | key_arr) & enable & ~clear & ~gameover_q & ~tick_serve;

  // rst_n gating keeps the ready output low while the block is held in reset.
  assign spawn_ready = rst_n & in_idle & enable & ~clear & ~gameover_q & free_vld &
                       ~pend_tick_q & ~pend_key_q & ~tick_arr & ~key_arr;
  assign spawn_go    = spawn_ready & spawn_valid;

  // Lowest-index free slot
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (!slot_vld_q[i]) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Slot under the walk pointer. y is always below LOWER_BOUND here, so the add cannot wrap.
  assign cur_vld    = slot_vld_q[idx_q];
  assign cur_ascii  = slot_ascii_q[idx_q];
  assign cur_y      = slot_y_q[idx_q];
  assign y_new      = cur_y + {7'd0, slot_spd_q[idx_q]};
  // After gameover, slots are frozen for display, so STEP only walks.
  assign step_wr    = (state_q == S_STEP) & enable & ~clear & ~gameover_q & cur_vld;
  assign step_miss  = step_wr & (y_new >= 10'(LOWER_BOUND));
  assign retire_hit = (state_q == S_RETIRE) & enable & ~clear & found_q;
  assign miss_inc   = miss_cnt_q + 2'd1;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pend_tick_d = pend_tick_q;
    pend_key_d  = pend_key_q;
    pend_code_d = pend_code_q;
    match_key_d = match_key_q;
    found_d     = found_q;
    best_idx_d  = best_idx_q;
    best_y_d    = best_y_q;
    score_d     = score_q;
    miss_cnt_d  = miss_cnt_q;
    gameover_d  = gameover_q;
    overrun_d   = overrun_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    wrong_d     = 1'b0;

    if (clear) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      pend_tick_d = 1'b0;
      pend_key_d  = 1'b0;
      pend_code_d = '0;
      match_key_d = '0;
      found_d     = 1'b0;
      best_idx_d  = '0;
      best_y_d    = '0;
      score_d     = '0;
      miss_cnt_d  = '0;
      gameover_d  = 1'b0;
      overrun_d   = 1'b0;
    end else if (enable) begin
      if (gameover_q) begin
        pend_tick_d = 1'b0;
        pend_key_d  = 1'b0;
      end else begin
        if (tick_serve)    pend_tick_d = 1'b0;
        else if (tick_arr) pend_tick_d = 1'b1;
        if (key_serve)     pend_key_d  = 1'b0;
        else if (key_arr)  pend_key_d  = 1'b1;
        // The most recent key code always wins.
        if (key_arr)       pend_code_d = key_ascii;
        if ((tick_arr && pend_tick_q) || (key_arr && pend_key_q)) overrun_d = 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (tick_serve) begin
            state_d = S_STEP;
            idx_d   = '0;
          end else if (key_serve) begin
            state_d     = S_MATCH;
            idx_d       = '0;
            found_d     = 1'b0;
            best_idx_d  = '0;
            best_y_d    = '0;
            match_key_d = key_arr ? key_ascii : pend_code_q;
          end
        end
        S_STEP: begin
          if (step_miss) begin
            miss_d     = 1'b1;
            miss_cnt_d = miss_inc;
            if (int'(miss_inc) >= MAX_MISS) gameover_d = 1'b1;
          end
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) state_d = S_IDLE;
        end
        S_MATCH: begin
          // A strict '>' keeps the lowest index on equal y.
          if (cur_vld && (cur_ascii == match_key_q) && (!found_q || (cur_y > best_y_q))) begin
            found_d    = 1'b1;
            best_idx_d = idx_q;
            best_y_d   = cur_y;
          end
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) state_d = S_RETIRE;
        end
        S_RETIRE: begin
          if (found_q) begin
            hit_d = 1'b1;
            if (int'(score_q) < SCORE_MAX) score_d = score_q + 8'd1;
          end else begin
            wrong_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pend_tick_q <= 1'b0;
      pend_key_q  <= 1'b0;
      pend_code_q <= '0;
      match_key_q <= '0;
      found_q     <= 1'b0;
      best_idx_q  <= '0;
      best_y_q    <= '0;
      score_q     <= '0;
      miss_cnt_q  <= '0;
      gameover_q  <= 1'b0;
      overrun_q   <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      wrong_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_tick_q <= pend_tick_d;
      pend_key_q  <= pend_key_d;
      pend_code_q <= pend_code_d;
      match_key_q <= match_key_d;
      found_q     <= found_d;
      best_idx_q  <= best_idx_d;
      best_y_q    <= best_y_d;
      score_q     <= score_d;
      miss_cnt_q  <= miss_cnt_d;
      gameover_q  <= gameover_d;
      overrun_q   <= overrun_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      wrong_q     <= wrong_d;
    end
  end

  // Slot array. Spawn, step and retire happen only in distinct FSM states, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOTS; i++) begin
        slot_vld_q[i]   <= 1'b0;
        slot_ascii_q[i] <= '0;
        slot_x_q[i]     <= '0;
        slot_y_q[i]     <= '0;
        slot_spd_q[i]   <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < NSLOTS; i++) slot_vld_q[i] <= 1'b0;
    end else begin
      if (spawn_go) begin
        slot_vld_q[free_idx]   <= 1'b1;
        slot_ascii_q[free_idx] <= spawn_ascii;
        slot_x_q[free_idx]     <= spawn_x;
        slot_y_q[free_idx]     <= '0;
        slot_spd_q[free_idx]   <= (spawn_speed == 3'd0) ? 3'd1 : spawn_speed;
      end
      if (step_wr) begin
        if (step_miss) slot_vld_q[idx_q] <= 1'b0;
        else           slot_y_q[idx_q]   <= y_new;
      end
      if (retire_hit) slot_vld_q[best_idx_q] <= 1'b0;
    end
  end

  // Renderer read port. It samples the array at the same edge that writes it, so it sees pre-update data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_ascii_q <= '0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
    end else begin
      rd_vld_q   <= slot_vld_q[rd_idx];
      rd_ascii_q <= slot_vld_q[rd_idx] ? slot_ascii_q[rd_idx] : 8'd0;
      rd_x_q     <= slot_vld_q[rd_idx] ? slot_x_q[rd_idx]     : 10'd0;
      rd_y_q     <= slot_vld_q[rd_idx] ? slot_y_q[rd_idx]     : 10'd0;
    end
  end

  assign rd_valid = rd_vld_q;
  assign rd_ascii = rd_ascii_q;
  assign rd_x     = rd_x_q;
  assign rd_y     = rd_y_q;
  assign hit      = hit_q;
  assign miss     = miss_q;
  assign wrong    = wrong_q;
  assign score    = score_q;
  assign miss_cnt = miss_cnt_q;
  assign gameover = gameover_q;
  assign busy     = (state_q != S_IDLE);
  assign overrun  = overrun_q;

endmodule
